serializer_multilane: RTL and testbench

//  Single-clock, multi-lane parallel-to-serial shifter for pseudo-differential video/serial links, running in the bit clock.

---
 rtl/serializer_multilane.sv | 145 ++++++++++++++
 tb/tb_serializer_multilane.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serializer_multilane.sv
// Multi-lane parallel-to-serial shifter with a word-aligned clock lane.
// A one-entry holding register decouples the valid/ready handshake from word boundaries.

module serializer_multilane_lane #(
  parameter int W         = 10,
  parameter int B         = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_rst_word,
  input  logic [W-1:0] i_word,
  output logic [B-1:0] o_bits
);
  logic [W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = (LSB_FIRST != 0) ? (sh_q >> B) : (sh_q << B);
    if (i_load) sh_d = i_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) sh_q <= i_rst_word;
    else       sh_q <= sh_d;
  end

  for (genvar b = 0; b < B; b++) begin : g_bit
    assign o_bits[b] = (LSB_FIRST != 0) ? sh_q[b] : sh_q[W-1-b];
  end
endmodule

module serializer_multilane #(
  parameter int                      p_data_width     = 10,
  parameter int                      p_lanes          = 3,
  parameter int                      p_bits_per_cycle = 2,
  parameter int                      p_lsb_first      = 1,
  parameter logic [p_data_width-1:0] p_idle_word      = '0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [p_lanes*p_data_width-1:0]       i_data,
  output logic [p_lanes*p_bits_per_cycle-1:0]   o_data,
  output logic [p_bits_per_cycle-1:0]           o_clk,
  output logic                                  o_load,
  output logic                                  o_underrun,
  input  logic                                  i_clr_underrun
);
  localparam int W  = p_data_width;
  localparam int B  = p_bits_per_cycle;
  localparam int L  = p_lanes;
  localparam int S  = W / B;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(S - 1);
  // Half ones in the low bits so they leave first through an LSB-first shifter.
  localparam logic [W-1:0]  CLK_PAT   = {{(W/2){1'b0}}, {(W/2){1'b1}}};

  if ((W % B) != 0 || (W % 2) != 0 || !(B == 1 || B == 2) || L < 1) begin : g_param_err
    $error("serializer_multilane: illegal parameter combination");
  end

  typedef struct packed {
    logic                 vld;
    logic [L-1:0][W-1:0]  data;
  } hold_t;

  hold_t               hold_q, hold_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic                load_q, load_d;
  logic                underrun_q, underrun_d;
  logic                load_cycle, accept, underrun_set;
  logic [L-1:0][W-1:0] in_words, load_words;
  logic [L-1:0][B-1:0] lane_bits;

  assign in_words   = i_data;
  assign load_cycle = (slot_q == LAST_SLOT);
  assign o_ready    = ~i_rst & (~hold_q.vld | load_cycle);
  assign accept     = i_valid & o_ready;

  always_comb begin
    slot_d       = load_cycle ? '0 : slot_q + SW'(1);
    hold_d       = hold_q;
    load_words   = hold_q.data;
    underrun_set = 1'b0;
    if (load_cycle) begin
      if (hold_q.vld) begin
        hold_d.vld = accept;
        if (accept) hold_d.data = in_words;
      end else if (accept) begin
        load_words = in_words;
      end else begin
        load_words   = {L{p_idle_word}};
        underrun_set = 1'b1;
      end
    end else if (accept) begin
      hold_d.vld  = 1'b1;
      hold_d.data = in_words;
    end
    load_d = load_cycle;
    // A fresh underrun wins over a simultaneous clear request.
    if (underrun_set)        underrun_d = 1'b1;
    else if (i_clr_underrun) underrun_d = 1'b0;
    else                     underrun_d = underrun_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_q     <= '0;
      hold_q     <= '0;
      load_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      hold_q     <= hold_d;
      load_q     <= load_d;
      underrun_q <= underrun_d;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    serializer_multilane_lane #(.W(W), .B(B), .LSB_FIRST(p_lsb_first)) u_lane (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (load_cycle),
      .i_rst_word (p_idle_word),
      .i_word     (load_words[k]),
      .o_bits     (lane_bits[k])
    );
  end

  serializer_multilane_lane #(.W(W), .B(B), .LSB_FIRST(1)) u_clk_lane (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load_cycle),
    .i_rst_word (CLK_PAT),
    .i_word     (CLK_PAT),
    .o_bits     (o_clk)
  );

  assign o_data     = lane_bits;
  assign o_load     = load_q;
  assign o_underrun = underrun_q;
endmodule

// File: tb/tb_serializer_multilane.sv
// Scoreboarded bench for serializer_multilane: W=10, B=2, L=3 LSB-first main instance
// plus a B=1 MSB-first single-lane instance.
module tb_serializer_multilane;
  localparam int L = 3, W = 10, B = 2, S = 5;
  typedef logic [L*W-1:0] word_t;
  localparam word_t        IDLE_WORD = '0;
  localparam logic [W-1:0] CLK_PAT   = 10'h01F;

  logic clk = 1'b0;
  logic rst, valid, clr, ready, oload, ounder;
  word_t data;
  logic [L*B-1:0] odata;
  logic [B-1:0]   oclk;
  logic v6, clr6, rdy6, ld6, ur6;
  logic [W-1:0] d6;
  logic [0:0] od6, oc6;

  int n_vec = 0;
  int n_err = 0;
  word_t exp_q[$];

  always #5 clk = ~clk;

  serializer_multilane dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_data(data),
    .o_data(odata), .o_clk(oclk), .o_load(oload), .o_underrun(ounder),
    .i_clr_underrun(clr)
  );

  serializer_multilane #(.p_data_width(10), .p_lanes(1), .p_bits_per_cycle(1),
                         .p_lsb_first(0)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_valid(v6), .o_ready(rdy6), .i_data(d6),
    .o_data(od6), .o_clk(oc6), .o_load(ld6), .o_underrun(ur6),
    .i_clr_underrun(clr6)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic word_t mk(input int n);
    mk = {10'(64 + 3*n + 2), 10'(64 + 3*n + 1), 10'(64 + 3*n)};
  endfunction

  // Land mid-cycle on slot n of the next word that starts.
  task automatic go_slot(input int n);
    int t = 0;
    @(negedge clk);
    while (!oload && t < 20) begin @(negedge clk); t++; end
    if (!oload) begin
      n_vec++; n_err++;
      $display("FAIL go_slot: no o_load within 20 cycles");
    end
    repeat (n) @(negedge clk);
  endtask

  // Monitor: rebuild each word from o_load onward and compare with the scoreboard.
  initial begin : monitor
    int slot;
    logic [L-1:0][W-1:0] acc;
    logic [W-1:0] cacc;
    word_t want;
    slot = -1; acc = '0; cacc = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) slot = -1;
      else begin
        if (oload) begin slot = 0; acc = '0; cacc = '0; end
        if (slot >= 0) begin
          for (int k = 0; k < L; k++) acc[k][slot*B +: B] = odata[k*B +: B];
          cacc[slot*B +: B] = oclk;
          slot++;
          if (slot == S) begin
            slot = -1;
            chk("clk_word", 64'(cacc), 64'(CLK_PAT));
            if (!(acc == IDLE_WORD && (exp_q.size() == 0 || exp_q[0] != IDLE_WORD))) begin
              if (exp_q.size() == 0) chk("word_unexpected", 64'(acc), 64'(IDLE_WORD));
              else begin
                want = exp_q.pop_front();
                chk("word", 64'(acc), 64'(want));
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0] clk_tab [5];
    logic [1:0] t2_tab  [5];
    int n_acc;
    int t;
    word_t a, bw, c;
    clk_tab = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    t2_tab  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    rst = 1; valid = 0; clr = 0; data = '0; v6 = 0; clr6 = 0; d6 = '0;

    // 1: reset, then idle stream with clock pattern and first underrun
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 64'(ready), 64'(0));
      chk("rst_load", 64'(oload), 64'(0));
      chk("rst_underrun", 64'(ounder), 64'(0));
    end
    rst = 0; #1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("t1_ready", 64'(ready), 64'(1));
      chk("t1_data", 64'(odata), 64'(0));
      chk("t1_clk", 64'(oclk), 64'(clk_tab[k % 5]));
      chk("t1_load", 64'(oload), 64'((k % 5 == 0) && k > 0));
      chk("t1_underrun", 64'(ounder), 64'(k >= 5));
    end

    // 2: bypass word in a load cycle
    go_slot(4);
    chk("t2_ready", 64'(ready), 64'(1));
    valid = 1; data = {10'h3FF, 10'h155, 10'h2A5}; exp_q.push_back(data);
    @(negedge clk); valid = 0;
    for (int s = 0; s < 5; s++) begin
      chk("t2_lane0", 64'(odata[1:0]), 64'(t2_tab[s]));
      chk("t2_load", 64'(oload), 64'(s == 0));
      if (s < 4) @(negedge clk);
    end

    // 3: continuous stream, clearing underrun on the first cycle
    go_slot(1);
    n_acc = 0;
    for (int cy = 0; cy < 40; cy++) begin
      valid = 1; data = mk(n_acc); clr = (cy == 0);
      if (ready) begin exp_q.push_back(mk(n_acc)); n_acc++; end
      @(negedge clk);
      chk("t3_underrun", 64'(ounder), 64'(0));
    end
    valid = 0; clr = 0;
    chk("t3_accepts", 64'(n_acc), 64'(9));

    // 5: starvation, clear request loses to a new underrun
    go_slot(4);
    chk("t5_underrun_pre", 64'(ounder), 64'(0));
    clr = 1;
    @(negedge clk); clr = 0;
    chk("t5_underrun_set", 64'(ounder), 64'(1));
    chk("t5_load", 64'(oload), 64'(1));
    chk("t5_idle", 64'(odata), 64'(0));

    // 4: accept into hold mid-word, then second word at the load cycle
    a = {10'h111, 10'h222, 10'h0F3}; bw = {10'h1C7, 10'h038, 10'h2DB};
    go_slot(1);
    chk("t4_ready_s1", 64'(ready), 64'(1));
    valid = 1; data = a; exp_q.push_back(a);
    @(negedge clk); valid = 0;
    chk("t4_ready_s2", 64'(ready), 64'(0));
    @(negedge clk);
    chk("t4_ready_s3", 64'(ready), 64'(0));
    @(negedge clk);
    chk("t4_ready_s4", 64'(ready), 64'(1));
    valid = 1; data = bw; exp_q.push_back(bw);
    @(negedge clk); valid = 0;
    chk("t4_a_load", 64'(oload), 64'(1));
    chk("t4_a_slot0", 64'(odata[1:0]), 64'(2'b11));

    // 4b: reset with hold full discards it and restarts at slot 0
    c = {10'h3A1, 10'h0B2, 10'h1C3};
    go_slot(1);
    chk("t4_c_ready", 64'(ready), 64'(1));
    valid = 1; data = c;
    @(negedge clk); valid = 0; rst = 1; #1;
    chk("t4_rst_ready", 64'(ready), 64'(0));
    @(negedge clk); rst = 0; exp_q.delete(); #1;
    chk("t4_post_data", 64'(odata), 64'(0));
    chk("t4_post_load", 64'(oload), 64'(0));
    chk("t4_post_clk", 64'(oclk), 64'(2'b11));
    chk("t4_post_underrun", 64'(ounder), 64'(0));
    chk("t4_post_ready", 64'(ready), 64'(1));
    for (int s = 1; s < 5; s++) begin
      @(negedge clk);
      chk("t4_post_noload", 64'(oload), 64'(0));
      chk("t4_post_idle", 64'(odata), 64'(0));
    end
    @(negedge clk);
    chk("t4_first_load", 64'(oload), 64'(1));
    chk("t4_first_underrun", 64'(ounder), 64'(1));
    chk("t4_no_stale_hold", 64'(odata), 64'(0));

    repeat (12) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    // 6: SDR, MSB-first instance
    t = 0;
    @(negedge clk);
    while (!ld6 && t < 30) begin @(negedge clk); t++; end
    chk("t6_sync", 64'(ld6), 64'(1));
    repeat (9) @(negedge clk);
    chk("t6_ready", 64'(rdy6), 64'(1));
    v6 = 1; d6 = 10'h200;
    @(negedge clk); v6 = 0;
    for (int s = 0; s < 10; s++) begin
      chk("t6_data", 64'(od6), 64'(s == 0));
      chk("t6_clk", 64'(oc6), 64'(s < 5));
      chk("t6_load", 64'(ld6), 64'(s == 0));
      if (s < 9) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
